// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, constants and packed-bus helpers for the
// multi-read-port register file (regfile_mp, regfile_clear_seq).
package regfile_pkg;

    // Sequencer state: clearing the array, or serving user traffic
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_e;

    // Register index that is hardwired to zero
    localparam int RF_ZERO_IDX = 0;

    // LSB position of a lane inside a packed multi-lane bus
    function automatic int rf_lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // MSB position of a lane inside a packed multi-lane bus
    function automatic int rf_lane_msb(input int lane, input int width);
        return (lane * width) + width - 1;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: clear sequencer for regfile_mp. Walks every register
// index once after reset and after each clear request, and gates user
// writes while doing so.
module regfile_clear_seq #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr_req,
    output logic          o_busy,
    output logic          o_wr_ready,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);
    import regfile_pkg::*;

    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic [AW-1:0]   w_clr_idx_nxt;

    // State and clear-index registers; reset restarts the clear from index 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= {AW{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Next-state logic: step through every index, leave CLEAR after the last one
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            RF_CLEAR: begin
                if (r_clr_idx == AW'(NREGS - 1)) begin
                    w_state_nxt   = RF_IDLE;
                    w_clr_idx_nxt = {AW{1'b0}};
                end else begin
                    w_state_nxt   = RF_CLEAR;
                    w_clr_idx_nxt = r_clr_idx + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            RF_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt   = RF_CLEAR;
                    w_clr_idx_nxt = {AW{1'b0}};
                end else begin
                    w_state_nxt   = RF_IDLE;
                    w_clr_idx_nxt = r_clr_idx;
                end
            end
            default: begin
                w_state_nxt   = RF_CLEAR;
                w_clr_idx_nxt = {AW{1'b0}};
            end
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        o_busy     = 1'b1;
        o_wr_ready = 1'b0;
        o_clr_we   = 1'b1;
        case (r_state)
            RF_CLEAR: begin
                o_busy     = 1'b1;
                o_wr_ready = 1'b0;
                o_clr_we   = 1'b1;
            end
            RF_IDLE: begin
                o_busy     = 1'b0;
                o_wr_ready = 1'b1;
                o_clr_we   = 1'b0;
            end
            default: begin
                o_busy     = 1'b1;
                o_wr_ready = 1'b0;
                o_clr_we   = 1'b1;
            end
        endcase
    end

    assign o_clr_addr = r_clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD combinational read ports, one synchronous write port with
// ready handshake, register 0 hardwired to zero, hardware clear sequencer.
// Optional feature: define RF_BYPASS_EN to forward an accepted same-cycle
// write to matching read lanes.
module regfile_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    output logic                wr_ready,
    input  logic                clr_req,
    output logic                busy
);
    import regfile_pkg::*;

    logic            w_busy;
    logic            w_wr_ready;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            w_usr_we;
    logic [XLEN-1:0] r_mem [NREGS];

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_wr_ready (w_wr_ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign busy     = w_busy;
    assign wr_ready = w_wr_ready;

    // Accepted user write; writes to the zero register are discarded
    assign w_usr_we = wr_en & w_wr_ready & (wr_addr != AW'(RF_ZERO_IDX));

    // Array write port: clear writes have priority (user writes are blocked then anyway)
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= {XLEN{1'b0}};
        end else if (w_usr_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_lane
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;

        assign w_addr = rd_addr[rf_lane_lsb(g, AW) +: AW];

        // Lane read mux: zero during clear and for register 0, else array (or bypass)
        always_comb begin
            w_data = {XLEN{1'b0}};
            if (w_busy || (w_addr == AW'(RF_ZERO_IDX))) begin
                w_data = {XLEN{1'b0}};
`ifdef RF_BYPASS_EN
            end else if (w_usr_we && (w_addr == wr_addr)) begin
                w_data = wr_data;
`endif
            end else begin
                w_data = r_mem[w_addr];
            end
        end

        assign rd_data[rf_lane_lsb(g, XLEN) +: XLEN] = w_data;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the single-cycle core datapath and its successors. It provides NRD combinational read ports and one synchronous write port with a ready handshake. Register 0 is hardwired to zero. A hardware clear sequencer zeroes every register after reset and on request. It replaces the fixed 32x32, two-read-port register file between the decode stage and the ALU/writeback paths.

## Interface
Parameters:
- XLEN, 32, data width in bits (≥8)
- NREGS, 32, number of registers (power of two, ≥4)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN]
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- wr_ready  out  1  write accepted this cycle if wr_en & wr_ready
- clr_req  in  1  single-cycle pulse; starts a full clear
- busy  out  1  clear sequence in progress

## Operation
- Two-state FSM: CLEAR, IDLE. rst forces CLEAR and clr_idx=0 asynchronously.
- CLEAR:
  - Each cycle, write 0 to Register[clr_idx], then increment clr_idx.
  - When clr_idx==NREGS-1, write it, then go to IDLE. The clear takes exactly NREGS cycles.
  - clr_req is ignored. busy=1, wr_ready=0. wr_en writes are dropped, not queued.
  - All rd_data lanes read 0.
- IDLE:
  - busy=0, wr_ready=1.
  - On clr_req=1, go to CLEAR with clr_idx=0. A wr_en in that same cycle is still accepted, then overwritten by the clear.
- Write: if wr_en & wr_ready & wr_addr!=0, Register[wr_addr] <= wr_data at the edge. Writes to address 0 are discarded.
- Read, per lane, combinational:
  - If rd_addr_i==0, return 0.
  - Otherwise return Register[rd_addr_i], subject to bypass (see Configuration).
- Multiple lanes may read the same address. Each returns an identical value.
- The array itself has no reset. Contents are defined only after the first CLEAR completes.

## Timing
- Values during and just after rst: busy=1, wr_ready=0, rd_data=0 on all lanes.
- Reads: zero-cycle latency, purely combinational from rd_addr, array and FSM state.
- Write-to-read latency:
  - 1 cycle without bypass: data is visible the cycle after acceptance.
  - 0 cycles with bypass.
- Clear: busy rises the cycle after an IDLE clr_req and stays high for NREGS cycles. The first IDLE cycle follows the final zero write.
- rst asserted mid-clear: the sequence restarts from index 0 after rst deasserts. Registers already zeroed stay zero.
- clr_req and rst together: rst wins.

## Configuration
- RF_BYPASS_EN defined:
  - A read lane whose nonzero rd_addr equals wr_addr while wr_en & wr_ready are high returns wr_data in the same cycle.
  - Bypass never applies during CLEAR, where lanes return 0.
- RF_BYPASS_EN undefined: read lanes always return the stored array value (old data during a same-cycle write).

## Structure
- regfile_pkg holds:
  - the state enum (RF_CLEAR, RF_IDLE)
  - the zero-register index constant RF_ZERO_IDX=0
  - the lane-slice helper functions for the packed buses
- Sub-module regfile_clear_seq owns:
  - the FSM and the clr_idx counter
  - the busy and wr_ready outputs
  - the clear write-enable and clear address into the array
- The top level muxes clear and user writes, instantiates the array, and generates the NRD read lanes.

## Test plan
- Reset release: assert rst 3 cycles, release. Required: busy=1 for exactly 32 cycles, then wr_ready=1. Reading addresses 1..31 returns 0x00000000.
- Basic write/read: write 0x00000030 to reg 9, then read reg 9 on lane 0 and reg 9 on lane 1 next cycle. Required: both lanes return 0x00000030.
- Zero register: write 0xDEADBEEF to reg 0. Required: a read of reg 0 returns 0 on every lane. wr_ready stays 1.
- Bypass: write 0x00000040 to reg 6 while lane 0 reads reg 6 in the same cycle.
  - With RF_BYPASS_EN: lane 0 returns 0x00000040 that cycle.
  - Without RF_BYPASS_EN: lane 0 returns the old value, and 0x00000040 the next cycle.
- Clear during traffic: load reg 11=0x28, pulse clr_req, and drive wr_en to reg 12 with 0x30 during CLEAR.
  - Required: wr_ready=0 for 32 cycles. After busy falls, reg 11 and reg 12 both read 0.
- Reset mid-clear: pulse clr_req, assert rst at clear cycle 10, release.
  - Required: busy stays high a full 32 cycles after release. Final contents are all zero.
